// File: rtl/decision_framer.sv
// rtl/decision_framer.sv - buffers decision words and serialises each into a 7-byte SYNC/TYPE/DATA/CHK frame.
// Optional: DECISION_FRAMER_CRC8_EN selects CRC-8 (poly 0x07) for CHK instead of the XOR checksum.
module decision_framer #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [7:0]                    in_type,
    input  logic [31:0]                   in_data,
    output logic                          in_ready,
    output logic [7:0]                    out_byte,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   drop_cnt
);
    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   LV_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_TYPE, S_D3, S_D2, S_D1, S_D0, S_CHK
    } state_t;

    logic [39:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic [15:0]   r_drop;

    state_t        r_state;
    logic [7:0]    r_type;
    logic [31:0]   r_data;
    logic [7:0]    r_chk;
    logic [7:0]    r_out_byte;
    logic          r_out_valid;

    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic [39:0]   w_head;

    // One checksum step per accepted byte keeps CHK ready exactly when its slot comes up.
    function automatic logic [7:0] chk_step(input logic [7:0] c, input logic [7:0] b);
`ifdef DECISION_FRAMER_CRC8_EN
        logic [7:0] r;
        r = c ^ b;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        end
        return r;
`else
        return c ^ b;
`endif
    endfunction

    assign w_full   = (r_level == LV_FULL);
    assign w_push   = in_valid && !w_full;
    assign w_head   = r_mem[r_rd_ptr];
    assign w_pop    = (r_level != '0) &&
                      ((r_state == S_IDLE) || ((r_state == S_CHK) && out_ready));

    assign in_ready   = !w_full;
    assign out_byte   = r_out_byte;
    assign out_valid  = r_out_valid;
    assign fifo_level = r_level;
    assign drop_cnt   = r_drop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_type, in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_drop   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
            if (in_valid && w_full && (r_drop != 16'hFFFF)) begin
                r_drop <= r_drop + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_type      <= '0;
            r_data      <= '0;
            r_chk       <= '0;
            r_out_byte  <= 8'h00;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        {r_type, r_data} <= w_head;
                        r_out_byte       <= SYNC_BYTE;
                        r_out_valid      <= 1'b1;
                        r_state          <= S_SYNC;
                    end
                end
                S_SYNC: if (out_ready) begin
                    r_out_byte <= r_type;
                    r_chk      <= chk_step(8'h00, r_type);
                    r_state    <= S_TYPE;
                end
                S_TYPE: if (out_ready) begin
                    r_out_byte <= r_data[31:24];
                    r_chk      <= chk_step(r_chk, r_data[31:24]);
                    r_state    <= S_D3;
                end
                S_D3: if (out_ready) begin
                    r_out_byte <= r_data[23:16];
                    r_chk      <= chk_step(r_chk, r_data[23:16]);
                    r_state    <= S_D2;
                end
                S_D2: if (out_ready) begin
                    r_out_byte <= r_data[15:8];
                    r_chk      <= chk_step(r_chk, r_data[15:8]);
                    r_state    <= S_D1;
                end
                S_D1: if (out_ready) begin
                    r_out_byte <= r_data[7:0];
                    r_chk      <= chk_step(r_chk, r_data[7:0]);
                    r_state    <= S_D0;
                end
                S_D0: if (out_ready) begin
                    r_out_byte <= r_chk;
                    r_state    <= S_CHK;
                end
                S_CHK: if (out_ready) begin
                    // Chain straight into the next frame when a word is waiting.
                    if (w_pop) begin
                        {r_type, r_data} <= w_head;
                        r_out_byte       <= SYNC_BYTE;
                        r_state          <= S_SYNC;
                    end else begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_decision_framer.sv
// tb/tb_decision_framer.sv - table-driven self-checking bench for decision_framer.
module tb_decision_framer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_type;
    logic [31:0] in_data;
    logic        in_ready;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  fifo_level;
    logic [15:0] drop_cnt;

    decision_framer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_type(in_type),
        .in_data(in_data), .in_ready(in_ready), .out_byte(out_byte),
        .out_valid(out_valid), .out_ready(out_ready), .fifo_level(fifo_level),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  typ;
        logic [31:0] data;
        int          mode;
        logic [7:0]  chk;
    } vec_t;

    vec_t        tbl [5];
    int          total = 0;
    int          bad   = 0;
    logic [39:0] pend [$];
    logic [7:0]  got  [$];
    logic [7:0]  expq [$];
    int          span;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] crc_model(input logic [7:0] t, input logic [31:0] d);
        logic [39:0] m;
        logic [7:0]  c;
        m = {t, d};
        c = 8'h00;
        for (int k = 39; k >= 0; k--) begin
            c = (c[7] ^ m[k]) ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    task automatic add_exp(input int idx);
        logic [7:0] c;
`ifdef DECISION_FRAMER_CRC8_EN
        c = crc_model(tbl[idx].typ, tbl[idx].data);
`else
        c = tbl[idx].chk;
`endif
        expq.push_back(8'hA5);
        expq.push_back(tbl[idx].typ);
        expq.push_back(tbl[idx].data[31:24]);
        expq.push_back(tbl[idx].data[23:16]);
        expq.push_back(tbl[idx].data[15:8]);
        expq.push_back(tbl[idx].data[7:0]);
        expq.push_back(c);
    endtask

    task automatic compare_bytes(input string name);
        check({name, "_count"}, got.size(), expq.size());
        for (int k = 0; k < expq.size() && k < got.size(); k++) begin
            check(name, got[k], expq[k]);
        end
        got.delete();
        expq.delete();
    endtask

    // Feeds pend[] one word per cycle and records accepted bytes; mode 1 toggles out_ready.
    task automatic run_collect(input int nbytes, input int mode, input int budget);
        logic       held_v;
        logic [7:0] held_b;
        logic       seen;
        logic       pushed;
        int         cyc;
        held_v = 1'b0;
        held_b = 8'h00;
        seen   = 1'b0;
        span   = 0;
        cyc    = 0;
        while (got.size() < nbytes && cyc < budget) begin
            out_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
            if (pend.size() > 0) begin
                in_valid = 1'b1;
                {in_type, in_data} = pend[0];
            end else begin
                in_valid = 1'b0;
            end
            if (held_v) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_byte", out_byte, held_b);
            end
            if (out_valid) seen = 1'b1;
            if (out_valid && out_ready) got.push_back(out_byte);
            held_v = out_valid && !out_ready;
            held_b = out_byte;
            pushed = in_valid && in_ready;
            if (seen) span++;
            tick();
            if (pushed) void'(pend.pop_front());
            cyc++;
        end
        in_valid = 1'b0;
        if (got.size() < nbytes) begin
            bad++;
            total++;
            $display("FAIL collect_timeout: got %0d bytes expected %0d", got.size(), nbytes);
        end
    endtask

    initial begin
        tbl[0] = '{8'h42, 32'h12345678, 0, 8'h4A};
        tbl[1] = '{8'h00, 32'h00000000, 1, 8'h00};
        tbl[2] = '{8'hFF, 32'hFFFFFFFF, 0, 8'hFF};
        tbl[3] = '{8'h81, 32'hDEADBEEF, 1, 8'hA3};
        tbl[4] = '{8'h5A, 32'hA5A5A5A5, 0, 8'h5A};

        rst_n = 1'b0; in_valid = 1'b0; in_type = '0; in_data = '0; out_ready = 1'b0;
        tick(); tick();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_byte", out_byte, 8'h00);
        check("rst_level", fifo_level, 3'd0);
        check("rst_drop", drop_cnt, 16'd0);
        check("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        tick();

        // Latency: accept at E0, SYNC visible after E1.
        out_ready = 1'b1;
        in_valid = 1'b1; in_type = tbl[0].typ; in_data = tbl[0].data;
        tick();
        in_valid = 1'b0;
        check("lat_e0_valid", out_valid, 1'b0);
        tick();
        check("lat_e1_valid", out_valid, 1'b1);
        check("lat_e1_byte", out_byte, 8'hA5);
        run_collect(7, 0, 40);
        add_exp(0);
        compare_bytes("t1_frame");
        check("t1_span", span, 7);

        for (int i = 0; i < 5; i++) begin
            pend.push_back({tbl[i].typ, tbl[i].data});
            run_collect(7, tbl[i].mode, 60);
            add_exp(i);
            compare_bytes("tbl_frame");
            tick(); tick();
            check("tbl_idle", out_valid, 1'b0);
        end

        // Overflow with stalled sink: one word sits in the frame register, four in the FIFO.
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_type = tbl[i % 5].typ; in_data = tbl[i % 5].data;
            tick();
        end
        in_valid = 1'b0;
        check("ovf_level", fifo_level, 3'd4);
        check("ovf_in_ready", in_ready, 1'b0);
        check("ovf_drop", drop_cnt, 16'd2);
        run_collect(35, 0, 200);
        for (int i = 0; i < 5; i++) add_exp(i);
        compare_bytes("ovf_frames");
        check("ovf_level_end", fifo_level, 3'd0);

        // Three words back-to-back: 21 bytes without a gap.
        for (int i = 1; i < 4; i++) pend.push_back({tbl[i].typ, tbl[i].data});
        run_collect(21, 0, 100);
        for (int i = 1; i < 4; i++) add_exp(i);
        compare_bytes("b2b_frames");
        check("b2b_span", span, 21);
        check("b2b_level", fifo_level, 3'd0);

        // Reset while the D2 byte is on the output.
        out_ready = 1'b1;
        in_valid = 1'b1; in_type = tbl[0].typ; in_data = tbl[0].data;
        tick();
        in_valid = 1'b1; in_type = tbl[2].typ; in_data = tbl[2].data;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        check("mid_d2_byte", out_byte, 8'h34);
        check("mid_drop_pre", drop_cnt, 16'd2);
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_level", fifo_level, 3'd0);
        check("mid_rst_drop", drop_cnt, 16'd0);
        rst_n = 1'b1;
        pend.push_back({tbl[4].typ, tbl[4].data});
        run_collect(7, 0, 40);
        add_exp(4);
        compare_bytes("post_rst_frame");

        // Saturation: first 5 pushes are absorbed, the rest count as drops.
        out_ready = 1'b0;
        in_valid = 1'b1; in_type = 8'h11; in_data = 32'h22334455;
        for (int i = 0; i < 5 + 65534; i++) tick();
        check("sat_drop_fffe", drop_cnt, 16'hFFFE);
        tick();
        check("sat_drop_ffff", drop_cnt, 16'hFFFF);
        for (int i = 0; i < 5; i++) tick();
        in_valid = 1'b0;
        check("sat_drop_hold", drop_cnt, 16'hFFFF);
        check("sat_level", fifo_level, 3'd4);
        check("sat_valid", out_valid, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
